alu_rr_arbiter: RTL and testbench

//  Shares the single combinational alu (A, B, ALUOp -> C) among NUM_REQ requesters.

---
 rtl/alu_rr_arbiter_pkg.sv | 24 ++
 rtl/alu_rr_arbiter_alu.sv | 32 +++
 rtl/alu_rr_arbiter_rr_pick.sv | 33 +++
 rtl/alu_rr_arbiter.sv | 106 ++++++++++
 tb/tb_alu_rr_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the alu round-robin arbiter:
// ALUOp codes, the illegal-op test and the result slot states.
package alu_rr_arbiter_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SRL = 3'b100,
      ALU_SRA = 3'b101
   } alu_op_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   // 110 and 111 have no alu meaning
   function automatic logic alu_op_illegal(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational alu: a, b, op -> c.
// Ports: a, b operands; op ALUOp; c result (0 for illegal ops).
module alu
   import alu_rr_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 3
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] c
);

   logic [4:0] sh;

   assign sh = b[4:0];

   always_comb begin
      c = '0;
      case (op)
         ALU_ADD: c = a + b;
         ALU_SUB: c = a - b;
         ALU_AND: c = a & b;
         ALU_OR:  c = a | b;
         ALU_SRL: c = a >> sh;
         ALU_SRA: c = $unsigned($signed(a) >>> sh);
         default: c = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req searching from ptr upward.
// Ports: req, ptr in; gnt one-hot, id encoded, any = some bit picked.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] id,
   output logic           any
);

   int idx;

   always_comb begin
      gnt = '0;
      id  = '0;
      any = 1'b0;
      idx = 0;
      for (int k = 0; k < N; k++) begin
         // rotate index, ptr is always < N
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            id       = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one alu among NUM_REQ requesters with round-robin grant
// and a registered single-entry valid/ready result slot.
// Ports: clk, reset_n (sync, active low); req_valid/req_ready and
// packed req_a/req_b/req_op per requester; rsp_valid/rsp_ready with
// rsp_id, rsp_c, rsp_err for the result slot.
module alu_rr_arbiter
   import alu_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_c,
   output logic                      rsp_err
);

   slot_e               state;
   slot_e               state_nxt;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     ptr_nxt;
   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gid;
   logic                any;
   logic                can_accept;
   logic                grant;
   logic [DATA_W-1:0]   a_sel;
   logic [DATA_W-1:0]   b_sel;
   logic [OP_W-1:0]     op_sel;
   logic [DATA_W-1:0]   c;

   rr_pick #(
      .N   (NUM_REQ),
      .IDW (ID_W)
   ) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .id  (gid),
      .any (any)
   );

   // slot frees in the same cycle it is drained
   assign can_accept = !rsp_valid || rsp_ready;
   assign grant      = reset_n && can_accept && any;
   assign req_ready  = grant ? gnt : '0;

   assign a_sel  = req_a[int'(gid)*DATA_W +: DATA_W];
   assign b_sel  = req_b[int'(gid)*DATA_W +: DATA_W];
   assign op_sel = req_op[int'(gid)*OP_W +: OP_W];

   alu #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .a  (a_sel),
      .b  (b_sel),
      .op (op_sel),
      .c  (c)
   );

   assign ptr_nxt = (gid == ID_W'(NUM_REQ-1)) ? '0 : gid + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= SLOT_EMPTY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         SLOT_EMPTY: if (grant) state_nxt = SLOT_FULL;
         SLOT_FULL:  if (rsp_ready && !grant) state_nxt = SLOT_EMPTY;
         default:    state_nxt = SLOT_EMPTY;
      endcase
   end

   always_comb begin
      rsp_valid = (state == SLOT_FULL);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr     <= '0;
         rsp_id  <= '0;
         rsp_c   <= '0;
         rsp_err <= 1'b0;
      end else if (grant) begin
         ptr     <= ptr_nxt;
         rsp_id  <= gid;
         rsp_c   <= c;
         rsp_err <= alu_op_illegal(op_sel);
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter against a
// behavioural model of the grant order and result slot.
module tb_alu_rr_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int DW = 32;
   localparam int OW = 3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*DW-1:0]  req_a;
   logic [N*DW-1:0]  req_b;
   logic [N*OW-1:0]  req_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IW-1:0]    rsp_id;
   logic [DW-1:0]    rsp_c;
   logic             rsp_err;

   int n_chk  = 0;
   int n_fail = 0;

   int          m_ptr;
   bit          m_valid;
   int          m_id;
   logic [31:0] m_c;
   bit          m_err;

   always #5 clk = ~clk;

   alu_rr_arbiter #(
      .NUM_REQ (N),
      .ID_W    (IW),
      .DATA_W  (DW),
      .OP_W    (OW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_c     (rsp_c),
      .rsp_err   (rsp_err)
   );

   function automatic logic [31:0] ref_alu(
      input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      int sh;
      sh = int'(b % 32);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a / (32'd1 << sh);
         3'd5: return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int exp_grant();
      if (!reset_n) return -1;
      if (m_valid && !rsp_ready) return -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int g;
      g = exp_grant();
      return (g < 0) ? '0 : (N'(1) << g);
   endfunction

   task automatic set_req(input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
      req_op[i*OW +: OW] = op;
   endtask

   task automatic rand_req(input int i);
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      set_req(i, $urandom, $urandom, op);
   endtask

   task automatic tick();
      int g;
      logic [31:0] a, b;
      logic [2:0] op;
      g = exp_grant();
      if (g >= 0) begin
         a  = req_a[g*DW +: DW];
         b  = req_b[g*DW +: DW];
         op = req_op[g*OW +: OW];
      end
      @(posedge clk);
      if (!reset_n) begin
         m_ptr = 0; m_valid = 0; m_id = 0; m_c = 0; m_err = 0;
      end else if (g >= 0) begin
         m_valid = 1;
         m_id    = g;
         m_c     = ref_alu(a, b, op);
         m_err   = (op >= 3'b110);
         m_ptr   = (g + 1) % N;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int i = 0; i < N; i++) rand_req(i);
      #1;
      n_chk++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 0", req_ready);
      end
      tick();
      tick();
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_c, rsp_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got v%b id%0d c%h e%b want all 0",
                  rsp_valid, rsp_id, rsp_c, rsp_err);
      end
      req_valid = '0;
      reset_n   = 1'b1;
   endtask

   task automatic test_basic_ops();
      logic [31:0] ta [4] = '{32'd7, 32'd7, 32'd7, 32'h80000000};
      logic [2:0]  top [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
      logic [31:0] tc [4] = '{32'd11, 32'd3, 32'd0, 32'hF8000000};
      rsp_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         set_req(0, ta[t], 32'd4, top[t]);
         req_valid = 4'b0001;
         #1;
         n_chk++;
         if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL basic_pre%0d: got v%b r%b want v0 r0001",
                     t, rsp_valid, req_ready);
         end
         tick();
         req_valid = '0;
         n_chk++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_c !== tc[t]
             || rsp_c !== m_c || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_op%0d: got v%b id%0d c%h e%b want v1 id0 c%h e0",
                     t, rsp_valid, rsp_id, rsp_c, rsp_err, tc[t]);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++) rand_req(i);
         #1;
         n_chk++;
         if (req_ready !== (N'(1) << (k % N))) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got %b want %b",
                     k, req_ready, N'(1) << (k % N));
         end
         tick();
         n_chk++;
         if (rsp_valid !== 1'b1 || int'(rsp_id) != k % N || rsp_c !== m_c
             || rsp_err !== m_err) begin
            n_fail++;
            $display("FAIL rr_rsp%0d: got v%b id%0d c%h want v1 id%0d c%h",
                     k, rsp_valid, rsp_id, rsp_c, k % N, m_c);
         end
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_back_pressure();
      int g;
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int i = 0; i < N; i++) rand_req(i);
      tick();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) rand_req(i);
         #1;
         n_chk++;
         if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL bp_ready%0d: got %b want 0", k, req_ready);
         end
         tick();
         n_chk++;
         if (rsp_valid !== 1'b1 || int'(rsp_id) != m_id || rsp_c !== m_c
             || rsp_err !== m_err) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v%b id%0d c%h want v1 id%0d c%h",
                     k, rsp_valid, rsp_id, rsp_c, m_id, m_c);
         end
      end
      rsp_ready = 1'b1;
      #1;
      g = exp_grant();
      n_chk++;
      if (g < 0 || req_ready !== exp_ready()) begin
         n_fail++;
         $display("FAIL bp_release: got %b want %b", req_ready, exp_ready());
      end
      tick();
      n_chk++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != g || rsp_c !== m_c) begin
         n_fail++;
         $display("FAIL bp_newrsp: got v%b id%0d c%h want v1 id%0d c%h",
                  rsp_valid, rsp_id, rsp_c, g, m_c);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_fairness();
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'd1, 3'b000);
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b1001;
      #1;
      n_chk++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL fair_first: got %b want 0001", req_ready);
      end
      tick();
      #1;
      n_chk++;
      if (rsp_id !== 2'd0 || req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL fair_second: got id%0d r%b want id0 r1000",
                  rsp_id, req_ready);
      end
      tick();
      n_chk++;
      if (rsp_id !== 2'd3 || rsp_c !== 32'd4) begin
         n_fail++;
         $display("FAIL fair_third: got id%0d c%h want id3 c4", rsp_id, rsp_c);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_illegal();
      rsp_ready = 1'b1;
      set_req(2, 32'h1234, 32'h5678, 3'b111);
      req_valid = 4'b0100;
      tick();
      n_chk++;
      if (rsp_c !== 32'd0 || rsp_err !== 1'b1 || rsp_id !== 2'd2) begin
         n_fail++;
         $display("FAIL illegal: got c%h e%b id%0d want c0 e1 id2",
                  rsp_c, rsp_err, rsp_id);
      end
      set_req(2, 32'd5, 32'd6, 3'b011);
      tick();
      n_chk++;
      if (rsp_c !== 32'd7 || rsp_err !== 1'b0 || rsp_id !== 2'd2) begin
         n_fail++;
         $display("FAIL illegal_clear: got c%h e%b id%0d want c7 e0 id2",
                  rsp_c, rsp_err, rsp_id);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         req_valid = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) rand_req(i);
         #1;
         n_chk++;
         if (req_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL rand_ready%0d: got %b want %b",
                     k, req_ready, exp_ready());
         end
         tick();
         n_chk++;
         if (rsp_valid !== m_valid || int'(rsp_id) != m_id
             || rsp_c !== m_c || rsp_err !== m_err) begin
            n_fail++;
            $display("FAIL rand_rsp%0d: got v%b id%0d c%h e%b want v%b id%0d c%h e%b",
                     k, rsp_valid, rsp_id, rsp_c, rsp_err,
                     m_valid, m_id, m_c, m_err);
         end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      rand_req(2);
      tick();
      reset_n   = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      #1;
      n_chk++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL rstmid_ready: got %b want 0", req_ready);
      end
      tick();
      n_chk++;
      if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_c !== 32'd0) begin
         n_fail++;
         $display("FAIL rstmid_state: got v%b id%0d c%h want v0 id0 c0",
                  rsp_valid, rsp_id, rsp_c);
      end
      reset_n = 1'b1;
      #1;
      n_chk++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rstmid_ptr: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_c = 0; m_err = 0;
      reset_n   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic_ops();
      test_round_robin();
      test_back_pressure();
      test_fairness();
      test_illegal();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
